// File: rtl/out_port_buf.sv
// Buffered output-port unit: NUM_CH latched output channels fed either directly
// (bypass) or through a tagged FIFO drained by a valid/ready consumer.
module out_port_buf #(
    parameter int DATA_W     = 8,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     out_we,
    input  logic [CH_W-1:0]          out_ch,
    input  logic [DATA_W-1:0]        out_data,
    input  logic                     bypass,
    output logic                     out_full,
    output logic                     ovf,
    output logic                     o_valid,
    output logic [CH_W-1:0]          o_ch,
    output logic [DATA_W-1:0]        o_data,
    input  logic                     o_ready,
    output logic [NUM_CH*DATA_W-1:0] O_Port
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t                          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]                r_rd_ptr, r_wr_ptr;
    logic [PTR_W:0]                  r_count;
    logic                            r_ovf;
    logic [NUM_CH-1:0][DATA_W-1:0]   r_port;

    logic [CH_W:0] w_ch_ext;
    logic          w_ch_ok, w_acc, w_byp_wr, w_push_req, w_push, w_pop, w_full;
    entry_t        w_head;

    // Channel indices past NUM_CH are silently ignored.
    assign w_ch_ext   = {1'b0, out_ch};
    assign w_ch_ok    = w_ch_ext < (CH_W+1)'(NUM_CH);
    assign w_acc      = out_we & w_ch_ok;
    assign w_byp_wr   = w_acc & bypass;
    assign w_push_req = w_acc & ~bypass;
    assign w_full     = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_pop      = o_valid & o_ready;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_head     = r_mem[r_rd_ptr];

    assign o_valid  = (r_count != '0);
    assign o_ch     = w_head.ch;
    assign o_data   = w_head.data;
    assign out_full = w_full;
    assign ovf      = r_ovf;
    assign O_Port   = r_port;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {out_ch, out_data};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
            if (w_push_req && w_full && !w_pop)
                r_ovf <= 1'b1;
        end
    end

    // A direct bypass write outranks a FIFO pop aimed at the same channel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_port <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_byp_wr && out_ch == CH_W'(k))
                    r_port[k] <= out_data;
                else if (w_pop && w_head.ch == CH_W'(k))
                    r_port[k] <= w_head.data;
            end
        end
    end
endmodule

// File: doc/out_port_buf.md
# out_port_buf

Parametrised, buffered output-port unit for the pipelined CPU wrapper. It replaces the single 8-bit latched `O_Port` register with NUM_CH output channels fed by a shared tagged FIFO, drained through a valid/ready handshake to external logic. A bypass mode keeps the legacy latch-on-write behaviour. It sits at the writeback side of the pipeline, driven by the OUT instruction.

## Interface

- DATA_W, 8, width of one output channel.
- NUM_CH, 2, number of output channels (1..16).
- FIFO_DEPTH, 4, FIFO entries; power of two, at least 2.
- CH_W, derived: max(1, clog2(NUM_CH)), channel-index width.

Ports:

- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- out_we  in  1  OUT instruction write strobe from WB, one per cycle.
- out_ch  in  CH_W  target channel.
- out_data  in  DATA_W  value to output (register operand of OUT).
- bypass  in  1  1 = legacy direct-latch mode for new writes.
- out_full  out  1  FIFO full; the pipeline stalls OUT while high.
- ovf  out  1  sticky flag: a FIFO push was dropped.
- o_valid  out  1  FIFO head valid (FIFO not empty).
- o_ch  out  CH_W  channel tag of the FIFO head.
- o_data  out  DATA_W  data of the FIFO head.
- o_ready  in  1  consumer accepts the head this cycle.
- O_Port  out  NUM_CH*DATA_W  held channel values; channel k is at bits [k*DATA_W +: DATA_W].

## Operation

- Write acceptance: a write is accepted when `out_we=1` and `out_ch < NUM_CH`. A write with `out_ch >= NUM_CH` is ignored, with no flag.
- bypass=1: the accepted write updates `O_Port[out_ch]` at the next edge. The FIFO is not pushed.
- bypass=0: the accepted write pushes {out_ch, out_data} into the FIFO at the tail.
- Pop: occurs when `o_valid & o_ready`. On that edge, `O_Port[o_ch] <= o_data`.
- Head outputs: `o_valid`, `o_ch` and `o_data` are read combinationally from the head entry.
- FIFO draining ignores `bypass`. Entries queued before a mode switch still drain and update `O_Port`.
- Pointers: rd_ptr and wr_ptr are clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count runs 0..FIFO_DEPTH.
- `out_full` = (count == FIFO_DEPTH).
- Push while full:
  - Accepted when a pop occurs on the same edge; count is unchanged.
  - Dropped otherwise, and `ovf <= 1`.
- Push and pop on the same edge while not full: both take effect and count is unchanged.
- Pop while empty: not possible, because `o_valid=0`.
- Same-edge `O_Port` conflict: a bypass write and a FIFO pop can target the same channel on the same edge. The bypass write wins.
- `ovf` is cleared only by reset.

## Timing

- Reset (asynchronous assert, synchronous-edge release): `O_Port` = 0, count = 0, rd_ptr = wr_ptr = 0, `ovf` = 0. This gives `o_valid` = 0 and `out_full` = 0. FIFO storage contents are don't-care.
- Bypass latency: `out_we` sampled at edge N gives `O_Port` updated after edge N.
- FIFO latency:
  - Push at edge N gives `o_valid` = 1 after edge N.
  - With `o_ready` = 1, the pop happens at edge N+1 and `O_Port` is updated after N+1. Write-to-pin latency is 2 edges.
- Throughput: one push and one pop per cycle sustained. A full FIFO with `o_ready` held high never drops a write.
- `out_full` reflects registered count only; it has no combinational path from `o_ready` or `out_we`.
- Reset mid-operation: queued entries are discarded. `O_Port` returns to 0 immediately, without waiting for a clock edge.

## Test plan

- Reset, then bypass=1; write ch0=0x55 at edge N -> `O_Port[7:0]` = 0x55 after edge N, `o_valid` stays 0. This is legacy `OUT R1` equivalence.
- bypass=0, `o_ready` = 1; write ch1=0xA3 -> `o_valid` = 1 with `o_ch` = 1 and `o_data` = 0xA3 for one cycle; `O_Port[15:8]` = 0xA3 two edges after the write; ch0 is unchanged.
- bypass=0, `o_ready` = 0; write 0x01..0x05 on consecutive cycles -> `out_full` = 1 after the 4th write, the 5th is dropped and `ovf` = 1. Then `o_ready` = 1 -> heads 0x01, 0x02, 0x03, 0x04 in order, and `o_valid` = 0 afterwards.
- Full FIFO, `o_ready` = 1 and `out_we` = 1 on the same cycle -> push accepted, count stays 4, `ovf` unchanged. Over 10 cycles of streaming, the wrap-around order is preserved.
- Queue ch0=0x11, switch to bypass=1, and write ch0=0x22 on the cycle the 0x11 pop occurs -> `O_Port[7:0]` = 0x22, since the bypass write wins.
- FIFO holding 3 entries, assert rstn=0 between edges -> `O_Port` = 0, `o_valid` = 0 and `ovf` = 0 immediately. After release, a new write behaves as after a clean reset.
